// File: rtl/key_pkg.sv
// Shared definitions for emulated-key blocks: LFSR seed/taps, bounce FSM states.
package key_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Bit indices of taps 16, 14, 13, 11 in a 16-bit register
  localparam int LFSR_TAP_A = 15;
  localparam int LFSR_TAP_B = 13;
  localparam int LFSR_TAP_C = 12;
  localparam int LFSR_TAP_D = 10;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS_BNC = 3'd1,
    HOLD      = 3'd2,
    REL_BNC   = 3'd3,
    DONE      = 3'd4
  } key_state_t;

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[LFSR_TAP_A] ^ v[LFSR_TAP_B] ^ v[LFSR_TAP_C] ^ v[LFSR_TAP_D]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, seeded on reset.
module lfsr16
  import key_pkg::*;
(
  input  logic        sys_clk,
  input  logic        sys_rst,
  output logic [15:0] value
);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) value <= LFSR_SEED;
    else         value <= lfsr_next(value);
  end

endmodule

// File: rtl/key_bounce_gen.sv
// Mechanical key emulator: one press_req yields a bounced fall, a long low hold,
// a bounced rise and a one-cycle done pulse.
module key_bounce_gen
  import key_pkg::*;
#(
  parameter logic [15:0] BOUNCE_MASK = 16'h0FFF,
  parameter logic [3:0]  BOUNCE_NUM  = 4'd7,
  parameter logic [25:0] HOLD_CNT    = 26'd49_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic press_req,
  output logic key_out,
  output logic busy,
  output logic done
);

  key_state_t  state, state_nxt;
  logic        key_nxt;
  logic [3:0]  bcnt, bcnt_nxt;
  logic [15:0] ivl, ivl_nxt;
  logic [25:0] hold, hold_nxt;
  logic [15:0] lfsr_val;
  logic [15:0] masked;
  logic [15:0] ivl_load;

  lfsr16 u_lfsr (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .value   (lfsr_val)
  );

  // Saturate so an all-ones mask and value can never wrap the interval to 0
  assign masked   = lfsr_val & BOUNCE_MASK;
  assign ivl_load = (masked == 16'hFFFF) ? 16'hFFFF : masked + 16'd1;

  always_comb begin
    state_nxt = state;
    key_nxt   = key_out;
    bcnt_nxt  = bcnt;
    ivl_nxt   = ivl;
    hold_nxt  = hold;
    case (state)
      IDLE: begin
        if (press_req) begin
          state_nxt = PRESS_BNC;
          key_nxt   = 1'b0;
          bcnt_nxt  = 4'd1;
          ivl_nxt   = ivl_load;
        end
      end
      PRESS_BNC, REL_BNC: begin
        if (ivl <= 16'd1) begin
          if (bcnt < BOUNCE_NUM) begin
            key_nxt  = ~key_out;
            bcnt_nxt = bcnt + 4'd1;
            ivl_nxt  = ivl_load;
          end else if (state == PRESS_BNC) begin
            state_nxt = HOLD;
            hold_nxt  = HOLD_CNT;
            ivl_nxt   = 16'd0;
          end else begin
            state_nxt = DONE;
            ivl_nxt   = 16'd0;
          end
        end else begin
          ivl_nxt = ivl - 16'd1;
        end
      end
      HOLD: begin
        if (hold <= 26'd1) begin
          state_nxt = REL_BNC;
          key_nxt   = 1'b1;
          bcnt_nxt  = 4'd1;
          ivl_nxt   = ivl_load;
          hold_nxt  = 26'd0;
        end else begin
          hold_nxt = hold - 26'd1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
        bcnt_nxt  = 4'd0;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // busy/done are registered from the next state so they align with it
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state   <= IDLE;
      key_out <= 1'b1;
      bcnt    <= 4'd0;
      ivl     <= 16'd0;
      hold    <= 26'd0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      key_out <= key_nxt;
      bcnt    <= bcnt_nxt;
      ivl     <= ivl_nxt;
      hold    <= hold_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
    end
  end

endmodule

// File: tb/tb_key_bounce_gen.sv
// Directed bench: dut_a (BOUNCE_NUM=5, HOLD_CNT=100) and dut_b (BOUNCE_NUM=1, HOLD_CNT=20).
module tb_key_bounce_gen;

  logic clk;
  logic rst_a, press_a, key_a, busy_a, done_a;
  logic rst_b, press_b, key_b, busy_b, done_b;
  logic [15:0] m_lfsr;
  int cyc;
  int n_tests, n_fail;

  key_bounce_gen #(.BOUNCE_MASK(16'h000F), .BOUNCE_NUM(4'd5), .HOLD_CNT(26'd100)) dut_a (
    .sys_clk(clk), .sys_rst(rst_a), .press_req(press_a),
    .key_out(key_a), .busy(busy_a), .done(done_a)
  );

  key_bounce_gen #(.BOUNCE_MASK(16'h000F), .BOUNCE_NUM(4'd1), .HOLD_CNT(26'd20)) dut_b (
    .sys_clk(clk), .sys_rst(rst_b), .press_req(press_b),
    .key_out(key_b), .busy(busy_b), .done(done_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) cyc <= cyc + 1;

  // Reference LFSR tracking dut_a, used to predict each bounce interval
  always_ff @(posedge clk) begin
    if (rst_a) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  // Follow dut_a from just after a press edge; every gap is compared to the model
  task automatic watch_a(input int budget, input logic [15:0] pm0, input bit inj,
                         input int repress, output int edges, output int dones,
                         output int gap_err, output int hold_gap, output bit tmo);
    logic prev_k;
    logic [15:0] pm;
    int last, exp_gap, n, left;
    bit pend, fin;
    edges = 1; dones = 0; gap_err = 0; hold_gap = 0; tmo = 0;
    prev_k = key_a; last = cyc; pm = m_lfsr;
    exp_gap = int'(pm0[3:0]) + 1;
    left = repress; pend = 0; fin = 0; n = 0;
    while (!fin && n < budget) begin
      @(negedge clk);
      n++;
      press_a = 1'b0;
      if (pend) begin press_a = 1'b1; pend = 0; end
      if (key_a !== prev_k) begin
        edges++;
        if (edges % 10 != 1) begin
          if (cyc - last != exp_gap) gap_err++;
          if (edges % 10 == 6) hold_gap = cyc - last;
        end
        exp_gap = int'(pm[3:0]) + 1 + ((edges % 10 == 5) ? 100 : 0);
        last = cyc; prev_k = key_a;
        if (inj && edges % 10 == 7) press_a = 1'b1;
      end
      if (inj && edges % 10 == 5 && cyc - last == 30) press_a = 1'b1;
      if (done_a === 1'b1) begin
        dones++;
        if (left > 0) begin left--; pend = 1; end
      end
      pm = m_lfsr;
      if (!busy_a && !pend && !press_a) fin = 1;
    end
    press_a = 1'b0;
    tmo = !fin;
  endtask

  task automatic press_dut_a(output logic [15:0] pm0);
    @(posedge clk); #1;
    press_a = 1'b1;
    pm0 = m_lfsr;
    @(posedge clk); #1;
    press_a = 1'b0;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    press_a = 1'b1; press_b = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (key_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: key=%b busy=%b done=%b, expected 1 0 0", key_a, busy_a, done_a);
    end
    n_tests++;
    if (dut_a.lfsr_val !== 16'hACE1) begin
      n_fail++;
      $display("FAIL reset_lfsr: got %h expected ace1", dut_a.lfsr_val);
    end
    rst_a = 1'b0; rst_b = 1'b0; press_a = 1'b0; press_b = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (busy_a !== 1'b0 || key_a !== 1'b1 || busy_b !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_press_ignored: busy_a=%b key_a=%b busy_b=%b, expected 0 1 0", busy_a, key_a, busy_b);
    end
  endtask

  task automatic test_lfsr();
    logic [15:0] exp_seq [3];
    exp_seq[0] = 16'h59C3; exp_seq[1] = 16'hB387; exp_seq[2] = 16'h670F;
    rst_a = 1'b1;
    @(posedge clk); #1;
    rst_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_tests++;
      if (dut_a.lfsr_val !== exp_seq[i]) begin
        n_fail++;
        $display("FAIL lfsr_step%0d: got %h expected %h", i, dut_a.lfsr_val, exp_seq[i]);
      end
    end
  endtask

  task automatic test_single_press();
    logic [15:0] pm0;
    int edges, dones, gerr, hgap;
    bit tmo;
    press_dut_a(pm0);
    n_tests++;
    if (key_a !== 1'b0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_first_fall: key=%b busy=%b, expected 0 1", key_a, busy_a);
    end
    watch_a(2000, pm0, 1'b0, 0, edges, dones, gerr, hgap, tmo);
    n_tests++;
    if (tmo || edges != 10) begin
      n_fail++;
      $display("FAIL single_edges: got %0d (timeout=%0d) expected 10", edges, tmo);
    end
    n_tests++;
    if (gerr != 0) begin
      n_fail++;
      $display("FAIL single_gaps: %0d gaps off model, expected 0", gerr);
    end
    n_tests++;
    if (hgap < 101 || hgap > 116) begin
      n_fail++;
      $display("FAIL single_hold_low: got %0d cycles, expected 101..116", hgap);
    end
    n_tests++;
    if (dones != 1 || key_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: dones=%0d key=%b busy=%b, expected 1 1 0", dones, key_a, busy_a);
    end
  endtask

  task automatic test_ignored_req();
    logic [15:0] pm0;
    int edges, dones, gerr, hgap;
    bit tmo;
    press_dut_a(pm0);
    watch_a(2000, pm0, 1'b1, 0, edges, dones, gerr, hgap, tmo);
    n_tests++;
    if (tmo || edges != 10 || dones != 1) begin
      n_fail++;
      $display("FAIL ignored_req: edges=%0d dones=%0d timeout=%0d, expected 10 1 0", edges, dones, tmo);
    end
    n_tests++;
    if (gerr != 0) begin
      n_fail++;
      $display("FAIL ignored_gaps: %0d gaps off model, expected 0", gerr);
    end
  endtask

  task automatic test_clean_press();
    logic prev_k;
    int edges, dones, last, rise_gap, n;
    @(posedge clk); #1;
    press_b = 1'b1;
    @(posedge clk); #1;
    press_b = 1'b0;
    n_tests++;
    if (key_b !== 1'b0) begin
      n_fail++;
      $display("FAIL clean_fall: key=%b expected 0", key_b);
    end
    edges = 1; dones = 0; last = cyc; rise_gap = 0; prev_k = key_b; n = 0;
    while (busy_b === 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
      if (key_b !== prev_k) begin
        edges++;
        if (edges == 2) rise_gap = cyc - last;
        prev_k = key_b;
      end
      if (done_b === 1'b1) dones++;
    end
    n_tests++;
    if (edges != 2 || dones != 1 || key_b !== 1'b1) begin
      n_fail++;
      $display("FAIL clean_seq: edges=%0d dones=%0d key=%b, expected 2 1 1", edges, dones, key_b);
    end
    n_tests++;
    if (rise_gap < 21 || rise_gap > 36) begin
      n_fail++;
      $display("FAIL clean_low_time: got %0d expected 21..36", rise_gap);
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] pm0;
    int edges, dones, gerr, hgap, n;
    bit tmo;
    press_dut_a(pm0);
    n = 0;
    while (dut_a.state != key_pkg::HOLD && n < 500) begin
      @(negedge clk);
      n++;
    end
    n_tests++;
    if (dut_a.state != key_pkg::HOLD) begin
      n_fail++;
      $display("FAIL abort_reach_hold: hold state not reached in %0d cycles", n);
    end
    repeat (49) @(posedge clk);
    #1 rst_a = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (key_a !== 1'b1 || busy_a !== 1'b0 || done_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: key=%b busy=%b done=%b, expected 1 0 0", key_a, busy_a, done_a);
    end
    rst_a = 1'b0;
    @(posedge clk); #1;
    press_a = 1'b1;
    pm0 = m_lfsr;
    n_tests++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_done: done=%b busy=%b, expected 0 0", done_a, busy_a);
    end
    @(posedge clk); #1;
    press_a = 1'b0;
    n_tests++;
    if (key_a !== 1'b0) begin
      n_fail++;
      $display("FAIL post_abort_fall: key=%b expected 0", key_a);
    end
    watch_a(2000, pm0, 1'b0, 0, edges, dones, gerr, hgap, tmo);
    n_tests++;
    if (tmo || edges != 10 || dones != 1 || gerr != 0) begin
      n_fail++;
      $display("FAIL post_abort_seq: edges=%0d dones=%0d gap_err=%0d timeout=%0d, expected 10 1 0 0",
               edges, dones, gerr, tmo);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] pm0;
    int edges, dones, gerr, hgap;
    bit tmo;
    press_dut_a(pm0);
    watch_a(4000, pm0, 1'b0, 1, edges, dones, gerr, hgap, tmo);
    n_tests++;
    if (tmo || edges != 20 || dones != 2) begin
      n_fail++;
      $display("FAIL b2b_seq: edges=%0d dones=%0d timeout=%0d, expected 20 2 0", edges, dones, tmo);
    end
    n_tests++;
    if (gerr != 0 || key_a !== 1'b1 || busy_a !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: gap_err=%0d key=%b busy=%b, expected 0 1 0", gerr, key_a, busy_a);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    rst_a = 1'b1; rst_b = 1'b1; press_a = 1'b0; press_b = 1'b0;
    test_reset();
    test_lfsr();
    test_single_press();
    test_ignored_req();
    test_clean_press();
    test_reset_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
